// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data/address widths, halt opcode and the instruction-length
// rule used by both fetch and control so they always agree on opcode length.
package cpu_pkg;

  localparam int BYTE_W = 8;
  localparam int ADDR_W = 8;

  localparam logic [BYTE_W-1:0] HLT_OPCODE           = 8'hF0;
  localparam logic [15:0]       DEFAULT_TWO_BYTE_MAP = 16'h000E;

  function automatic logic is_two_byte(input logic [BYTE_W-1:0] opcode,
                                       input logic [15:0]       map);
    return map[opcode[7:4]];
  endfunction

endpackage

// File: rtl/fetch_byte_fifo.sv
// Circular byte queue for the fetch stage: 1-byte push, 1- or 2-byte pop, flush,
// occupancy count and a peek at the head byte and the byte after it.
module fetch_byte_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [BYTE_W-1:0]          push_data_i,
  input  logic                       pop_i,
  input  logic                       pop_two_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic [BYTE_W-1:0]          head_byte_o,
  output logic [BYTE_W-1:0]          next_byte_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [BYTE_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [PTR_W-1:0]  head_next_s;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  pop_len_s;

  // Next-state for storage, pointers and count; push and pop in one cycle both apply.
  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (!pop_i) begin
      pop_len_s = {CNT_W{1'b0}};
    end else if (pop_two_i) begin
      pop_len_s = CNT_W'(2'd2);
    end else begin
      pop_len_s = CNT_W'(1'b1);
    end
    if (flush_i) begin
      head_d  = {PTR_W{1'b0}};
      tail_d  = {PTR_W{1'b0}};
      count_d = {CNT_W{1'b0}};
    end else begin
      if (push_i) begin
        mem_d[tail_q] = push_data_i;
        tail_d        = tail_q + PTR_W'(1'b1);
      end else begin
        tail_d = tail_q;
      end
      head_d  = head_q + PTR_W'(pop_len_s);
      count_d = count_q + CNT_W'(push_i) - pop_len_s;
    end
  end

  // Queue state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q   <= '{default: {BYTE_W{1'b0}}};
      head_q  <= {PTR_W{1'b0}};
      tail_q  <= {PTR_W{1'b0}};
      count_q <= {CNT_W{1'b0}};
    end else begin
      mem_q   <= mem_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_next_s = head_q + PTR_W'(1'b1);
  assign count_o     = count_q;
  assign head_byte_o = mem_q[head_q];
  assign next_byte_o = mem_q[head_next_s];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues byte reads to a 1-cycle instruction memory, queues the bytes and
// presents whole 1- or 2-byte instructions to decode, with redirect/flush and HLT stop.
module instr_fetch_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH        = 4,
  parameter logic [15:0] TWO_BYTE_MAP = DEFAULT_TWO_BYTE_MAP,
  parameter logic [7:0]  OP_HLT       = HLT_OPCODE
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [BYTE_W-1:0] imem_rdata_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [BYTE_W-1:0] out_opcode_o,
  output logic [BYTE_W-1:0] out_imm_o,
  output logic              out_two_byte_o,
  output logic [ADDR_W-1:0] out_pc_o,
  output logic              halted_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] head_pc_q, head_pc_d;
  logic              inflight_q, inflight_d;
  logic              halted_q, halted_d;

  logic [CNT_W-1:0]  count_s;
  logic [BYTE_W-1:0] head_byte_s;
  logic [BYTE_W-1:0] next_byte_s;
  logic [OCC_W-1:0]  occ_s;
  logic              two_s;
  logic              valid_s;
  logic              pop_s;
  logic              push_s;
  logic              req_s;

  fetch_byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_i),
    .push_i      (push_s),
    .push_data_i (imem_rdata_i),
    .pop_i       (pop_s),
    .pop_two_i   (two_s),
    .count_o     (count_s),
    .head_byte_o (head_byte_s),
    .next_byte_o (next_byte_s)
  );

  // Handshake and issue decisions; counting the in-flight read guarantees its data fits.
  always_comb begin
    two_s = is_two_byte(head_byte_s, TWO_BYTE_MAP);
    occ_s = OCC_W'(count_s) + OCC_W'(inflight_q);
    if (two_s) begin
      valid_s = !halted_q && (count_s >= CNT_W'(2'd2));
    end else begin
      valid_s = !halted_q && (count_s != {CNT_W{1'b0}});
    end
    pop_s  = valid_s && out_ready_i && !redirect_i;
    push_s = inflight_q && !redirect_i && !halted_q;
    req_s  = !halted_q && !redirect_i && (occ_s < DEPTH_OCC);
  end

  // PC, halt and in-flight next-state; a redirect overrides any same-cycle pop.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    halted_d   = halted_q;
    inflight_d = req_s;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i;
      head_pc_d  = redirect_pc_i;
      halted_d   = 1'b0;
    end else begin
      if (req_s) begin
        fetch_pc_d = fetch_pc_q + 8'd1;
      end else begin
        fetch_pc_d = fetch_pc_q;
      end
      if (pop_s) begin
        head_pc_d = head_pc_q + (two_s ? 8'd2 : 8'd1);
        halted_d  = halted_q | (head_byte_s == OP_HLT);
      end else begin
        head_pc_d = head_pc_q;
        halted_d  = halted_q;
      end
    end
  end

  // Control registers; reset also kills any read that is still in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= {ADDR_W{1'b0}};
      head_pc_q  <= {ADDR_W{1'b0}};
      inflight_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      inflight_q <= inflight_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_req_o     = req_s && !rst;
  assign imem_addr_o    = fetch_pc_q;
  assign out_valid_o    = valid_s;
  assign out_opcode_o   = head_byte_s;
  assign out_imm_o      = two_s ? next_byte_s : 8'h00;
  assign out_two_byte_o = two_s;
  assign out_pc_o       = head_pc_q;
  assign halted_o       = halted_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed cycle tables, stall/reset sequences and a
// randomized run checked against a program-order instruction stream model.
module tb_instr_fetch_queue;

  typedef struct {
    logic       rdy;
    logic       redir;
    logic [7:0] rpc;
    logic       e_req;
    logic [7:0] e_addr;
    logic       e_valid;
    logic [7:0] e_op;
    logic [7:0] e_imm;
    logic       e_two;
    logic [7:0] e_pc;
    logic       e_halt;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       imem_req_o;
  logic [7:0] imem_addr_o;
  logic [7:0] imem_rdata_i;
  logic       redirect_i = 1'b0;
  logic [7:0] redirect_pc_i = 8'h00;
  logic       out_valid_o;
  logic       out_ready_i = 1'b0;
  logic [7:0] out_opcode_o;
  logic [7:0] out_imm_o;
  logic       out_two_byte_o;
  logic [7:0] out_pc_o;
  logic       halted_o;

  logic [7:0]  mem [0:255];
  logic [15:0] two_map = 16'h000E;
  vec_t        tbl[$];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  // Instruction memory: data for the address presented now appears next cycle.
  always @(posedge clk) imem_rdata_i <= mem[imem_addr_o];

  instr_fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_o     (imem_req_o),
    .imem_addr_o    (imem_addr_o),
    .imem_rdata_i   (imem_rdata_i),
    .redirect_i     (redirect_i),
    .redirect_pc_i  (redirect_pc_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_opcode_o   (out_opcode_o),
    .out_imm_o      (out_imm_o),
    .out_two_byte_o (out_two_byte_o),
    .out_pc_o       (out_pc_o),
    .halted_o       (halted_o)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic rdy, input logic redir, input logic [7:0] rpc,
                               input logic e_req, input logic [7:0] e_addr,
                               input logic e_valid, input logic [7:0] e_op,
                               input logic [7:0] e_imm, input logic e_two,
                               input logic [7:0] e_pc, input logic e_halt);
    vec_t v;
    v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr;
    v.e_valid = e_valid; v.e_op = e_op; v.e_imm = e_imm; v.e_two = e_two; v.e_pc = e_pc;
    v.e_halt = e_halt;
    return v;
  endfunction

  task automatic cyc(input logic rdy, input logic redir, input logic [7:0] rpc);
    @(negedge clk);
    out_ready_i   = rdy;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {imem_req_o, out_valid_o, halted_o, out_two_byte_o,
               imem_addr_o, out_pc_o, out_opcode_o, out_imm_o}, 64'd0);
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst           = 1'b1;
    out_ready_i   = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 8'h00;
    #1;
    chk_all_zero("reset.outs");
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic run_rows(input int first, input int last, input string tag);
    vec_t v;
    for (int i = first; i <= last; i++) begin
      v = tbl[i];
      cyc(v.rdy, v.redir, v.rpc);
      chk($sformatf("%s[%0d].req", tag, i), imem_req_o, v.e_req);
      if (v.e_req) chk($sformatf("%s[%0d].addr", tag, i), imem_addr_o, v.e_addr);
      chk($sformatf("%s[%0d].valid", tag, i), out_valid_o, v.e_valid);
      if (v.e_valid)
        chk($sformatf("%s[%0d].instr", tag, i),
            {out_opcode_o, out_imm_o, out_two_byte_o, out_pc_o},
            {v.e_op, v.e_imm, v.e_two, v.e_pc});
      chk($sformatf("%s[%0d].halted", tag, i), halted_o, v.e_halt);
    end
  endtask

  task automatic load_basic();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[8'h00] = 8'h10; mem[8'h01] = 8'hAB; mem[8'h02] = 8'h05; mem[8'h03] = 8'hF0;
    mem[8'h40] = 8'h05; mem[8'h41] = 8'hF0;
  endtask

  task automatic load_wrap();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[8'hFE] = 8'h05; mem[8'hFF] = 8'h17; mem[8'h00] = 8'h22; mem[8'h01] = 8'hF0;
  endtask

  task automatic stall_test();
    int         reqs;
    int         changes;
    int         np;
    logic       seen;
    logic [24:0] snap;
    logic [7:0] e_pcs [3];
    logic [7:0] e_ops [3];
    e_pcs[0] = 8'h00; e_pcs[1] = 8'h02; e_pcs[2] = 8'h03;
    e_ops[0] = 8'h10; e_ops[1] = 8'h05; e_ops[2] = 8'hF0;
    reqs = 0; changes = 0; np = 0; seen = 1'b0; snap = 25'd0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b0, 1'b0, 8'h00);
      if (imem_req_o) reqs++;
      if (out_valid_o) begin
        if (seen && ({out_opcode_o, out_imm_o, out_two_byte_o, out_pc_o} != snap)) changes++;
        snap = {out_opcode_o, out_imm_o, out_two_byte_o, out_pc_o};
        seen = 1'b1;
      end else if (seen) begin
        changes++;
      end
    end
    chk("stall.reqs", reqs, 4);
    chk("stall.stable", changes, 0);
    chk("stall.valid", seen, 1'b1);
    for (int i = 0; i < 20 && np < 3; i++) begin
      cyc(1'b1, 1'b0, 8'h00);
      if (out_valid_o) begin
        chk($sformatf("stall.pc%0d", np), out_pc_o, e_pcs[np]);
        chk($sformatf("stall.op%0d", np), out_opcode_o, e_ops[np]);
        np++;
      end
    end
    chk("stall.npops", np, 3);
  endtask

  task automatic random_test();
    logic [7:0]  exp_pc_m, fetch_m, op, imm, tgt;
    logic        halted_m, hold_m, two, rdy, rd;
    logic [24:0] snap_m;
    int          outst, accepted;
    for (int a = 0; a < 256; a++)
      mem[a] = ($urandom_range(0, 29) == 0) ? 8'hF0 : 8'($urandom);
    reset_dut();
    exp_pc_m = 8'h00; fetch_m = 8'h00; halted_m = 1'b0; hold_m = 1'b0;
    snap_m = 25'd0; outst = 0; accepted = 0;
    for (int c = 0; c < 3000; c++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rd  = ($urandom_range(0, 24) == 0) || (halted_m && ($urandom_range(0, 4) == 0));
      tgt = 8'($urandom_range(0, 255));
      cyc(rdy, rd, tgt);
      chk("rnd.halted", halted_o, halted_m);
      if (halted_m) chk("rnd.idle", {imem_req_o, out_valid_o}, 2'b00);
      if (hold_m)
        chk("rnd.stable", {out_valid_o, out_opcode_o, out_imm_o, out_two_byte_o, out_pc_o},
            {1'b1, snap_m});
      if (rd) chk("rnd.redir_noreq", imem_req_o, 1'b0);
      if (imem_req_o) begin
        chk("rnd.addr", imem_addr_o, fetch_m);
        fetch_m = fetch_m + 8'd1;
        outst++;
      end
      chk("rnd.outstanding", outst <= 4, 1'b1);
      if (rd) begin
        exp_pc_m = tgt; fetch_m = tgt; halted_m = 1'b0; outst = 0; hold_m = 1'b0;
      end else if (out_valid_o && out_ready_i) begin
        op  = mem[exp_pc_m];
        two = two_map[op[7:4]];
        imm = two ? mem[exp_pc_m + 8'd1] : 8'h00;
        chk("rnd.instr", {out_opcode_o, out_imm_o, out_two_byte_o, out_pc_o},
            {op, imm, two, exp_pc_m});
        exp_pc_m = exp_pc_m + (two ? 8'd2 : 8'd1);
        outst    = outst - (two ? 2 : 1);
        accepted++;
        if (op == 8'hF0) halted_m = 1'b1;
        hold_m = 1'b0;
      end else begin
        hold_m = out_valid_o;
        snap_m = {out_opcode_o, out_imm_o, out_two_byte_o, out_pc_o};
      end
    end
    chk("rnd.progress", accepted > 100, 1'b1);
  endtask

  initial begin
    // basic program, then HLT and redirect back to 00 (rows 0..12)
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'h10, 8'hAB, 1'b1, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'h04, 1'b1, 8'h05, 8'h00, 1'b0, 8'h02, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'h05, 1'b1, 8'hF0, 8'h00, 1'b0, 8'h03, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1));
    tbl.push_back(mkv(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'h10, 8'hAB, 1'b1, 8'h00, 1'b0));
    // redirect to 40 while a response is pending and out_valid=1 (rows 13..21)
    tbl.push_back(mkv(1'b0, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b0, 1'b0, 8'h00, 1'b1, 8'h02, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b1, 8'h40, 1'b0, 8'h00, 1'b1, 8'h10, 8'hAB, 1'b1, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'h40, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'h42, 1'b1, 8'h05, 8'h00, 1'b0, 8'h40, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'h43, 1'b1, 8'hF0, 8'h00, 1'b0, 8'h41, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1));
    // program straddling FF->00 (rows 22..29)
    tbl.push_back(mkv(1'b1, 1'b1, 8'hFE, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'hFE, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 8'h05, 8'h00, 1'b0, 8'hFE, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'h02, 1'b1, 8'h17, 8'h22, 1'b1, 8'hFF, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 1'b1, 8'hF0, 8'h00, 1'b0, 8'h01, 1'b0));
    tbl.push_back(mkv(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1));

    load_basic();
    reset_dut();
    run_rows(0, 12, "basic");

    reset_dut();
    stall_test();

    reset_dut();
    run_rows(13, 21, "redir");

    load_wrap();
    reset_dut();
    run_rows(22, 29, "wrap");

    // asynchronous reset in the middle of a stream
    load_basic();
    reset_dut();
    run_rows(0, 3, "pre_rst");
    #1 rst = 1'b1;
    #1 chk_all_zero("midrst.outs");
    @(posedge clk);
    #2 rst = 1'b0;
    run_rows(0, 7, "post_rst");

    random_test();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
